// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler
//   Paced transmit scheduler for the L2 switch simulator. Frames entered by the
//   user logic are held in a 4-entry circular FIFO. A send request clears the
//   switch FIFOs once and then dispatches the queued frames in arrival order,
//   each to the port of its source node. GAP_CYCLES idle cycles follow every
//   dispatch so that serial frames never overlap inside the switch.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   add_req         enqueue pulse for add_frame / add_src
//   add_frame       {SFD, DST, SRC, PAYLOAD} nibbles
//   add_src         transmitting node index (0=A .. 3=D)
//   send_req        start a dispatch burst (honoured only when idle)
//   tx_frame_flat   per-port frame, port p at [16p+15:16p], held between dispatches
//   tx_valid        one-cycle dispatch strobe, one bit per port
//   clear_fifos     one-cycle pulse to the switch at burst start
//   queue_count     frames currently queued (0..4)
//   full            queue holds 4 frames
//   busy            burst in progress
//   drop            add_req rejected because the queue was full
//   done            burst finished (also pulsed for a send on an empty queue)
module frame_tx_scheduler #(
  parameter int GAP_CYCLES = 40,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        add_req,
  input  logic [15:0] add_frame,
  input  logic [1:0]  add_src,
  input  logic        send_req,
  output logic [63:0] tx_frame_flat,
  output logic [3:0]  tx_valid,
  output logic        clear_fifos,
  output logic [2:0]  queue_count,
  output logic        full,
  output logic        busy,
  output logic        drop,
  output logic        done
);

  localparam int              GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [2:0]      FULL_CNT = 3'(DEPTH);
  localparam logic [GW-1:0]   GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [GW-1:0]   GAP_LAST = GW'(1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [15:0]   q_frame [4];
  logic [1:0]    q_src   [4];
  logic [1:0]    head;
  logic [1:0]    tail;
  logic [2:0]    count;
  logic [2:0]    count_nxt;
  logic [GW-1:0] gap_cnt;
  logic          push;
  logic          pop;
  logic          load;
  logic          empty_send;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (send_req && count != 3'd0) state_nxt = S_CLEAR;
      S_CLEAR:    state_nxt = S_DISPATCH;
      S_DISPATCH: state_nxt = S_GAP;
      S_GAP:      if (gap_cnt == GAP_LAST)
                    state_nxt = (count != 3'd0) ? S_DISPATCH : S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded on the edge entering DISPATCH from the current
  // head; the head itself is retired on the edge leaving DISPATCH. A pop frees
  // a slot in the same cycle, so an add against a full queue is then accepted.
  assign load       = (state_nxt == S_DISPATCH);
  assign pop        = (state == S_DISPATCH);
  assign push       = add_req && ((count != FULL_CNT) || pop);
  assign count_nxt  = count + {2'b00, push} - {2'b00, pop};
  assign empty_send = (state == S_IDLE) && send_req && (count == 3'd0);

  assign queue_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      head          <= 2'd0;
      tail          <= 2'd0;
      count         <= 3'd0;
      gap_cnt       <= '0;
      tx_frame_flat <= 64'd0;
      tx_valid      <= 4'd0;
      clear_fifos   <= 1'b0;
      full          <= 1'b0;
      busy          <= 1'b0;
      drop          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      full        <= (count_nxt == FULL_CNT);
      drop        <= add_req && !push;
      clear_fifos <= (state_nxt == S_CLEAR);
      busy        <= (state_nxt != S_IDLE);
      done        <= empty_send || (state_nxt == S_DONE);
      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;

      if (state == S_DISPATCH)  gap_cnt <= GAP_LOAD;
      else if (state == S_GAP)  gap_cnt <= gap_cnt - GAP_LAST;

      tx_valid <= 4'd0;
      if (load) begin
        tx_valid <= 4'b0001 << q_src[head];
        tx_frame_flat[{q_src[head], 4'b0000} +: 16] <= q_frame[head];
      end
    end
  end

  // Queue storage carries no reset; head/tail/count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_frame[tail] <= add_frame;
      q_src[tail]   <= add_src;
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        add_req;
  logic [15:0] add_frame;
  logic [1:0]  add_src;
  logic        send_req;
  logic [63:0] tx_frame_flat;
  logic [3:0]  tx_valid;
  logic        clear_fifos;
  logic [2:0]  queue_count;
  logic        full;
  logic        busy;
  logic        drop;
  logic        done;

  frame_tx_scheduler #(.GAP_CYCLES(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .add_req(add_req), .add_frame(add_frame),
    .add_src(add_src), .send_req(send_req), .tx_frame_flat(tx_frame_flat),
    .tx_valid(tx_valid), .clear_fifos(clear_fifos), .queue_count(queue_count),
    .full(full), .busy(busy), .drop(drop), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    int          port;
    logic [15:0] frame;
  } tx_exp_t;

  tx_exp_t txq[$];
  int      clrq[$];
  int      doneq[$];
  int      dropq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic exp_tx(input int at, input int port, input logic [15:0] frame);
    tx_exp_t e;
    e.at = at; e.port = port; e.frame = frame;
    txq.push_back(e);
  endtask

  // Monitor: samples on the falling edge and retires scoreboard entries.
  always @(negedge clk) begin
    if (tx_valid != 4'd0) begin
      if (txq.size() == 0) unexpected("tx_valid");
      else begin
        tx_exp_t e;
        logic [3:0] onehot;
        e = txq.pop_front();
        onehot = 4'b0001 << e.port;
        check("tx_cycle", 64'(cyc), 64'(e.at));
        check("tx_valid", 64'(tx_valid), 64'(onehot));
        check("tx_frame", 64'(tx_frame_flat[e.port*16 +: 16]), 64'(e.frame));
      end
    end
    if (clear_fifos) begin
      if (clrq.size() == 0) unexpected("clear_fifos");
      else check("clear_cycle", 64'(cyc), 64'(clrq.pop_front()));
    end
    if (done) begin
      if (doneq.size() == 0) unexpected("done");
      else check("done_cycle", 64'(cyc), 64'(doneq.pop_front()));
    end
    if (drop) begin
      if (dropq.size() == 0) unexpected("drop");
      else check("drop_cycle", 64'(cyc), 64'(dropq.pop_front()));
    end
  end

  // Drivers run on the falling edge; the following rising edge samples them.
  task automatic add(input logic [15:0] frame, input logic [1:0] src, input bit exp_drop);
    if (exp_drop) dropq.push_back(cyc + 1);
    add_req = 1'b1; add_frame = frame; add_src = src;
    @(negedge clk);
    add_req = 1'b0;
  endtask

  task automatic send();
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    bit quiet;
    rst = 1'b1; add_req = 1'b0; add_frame = 16'h0; add_src = 2'd0; send_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_frame", tx_frame_flat, 64'h0);
    check("rst_tx_valid", 64'(tx_valid), 64'h0);
    check("rst_clear", 64'(clear_fifos), 64'h0);
    check("rst_count", 64'(queue_count), 64'h0);
    check("rst_full", 64'(full), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_drop", 64'(drop), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    rst = 1'b0;

    // Idle: nothing moves for 100 cycles.
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx_frame_flat != 0 || tx_valid != 0 || clear_fifos || queue_count != 0 ||
          full || busy || drop || done) quiet = 1'b0;
    end
    check("idle_quiet", 64'(quiet), 64'h1);

    // Send on an empty queue: done only.
    s = cyc;
    doneq.push_back(s + 1);
    send();
    repeat (3) @(negedge clk);
    check("empty_send_busy", 64'(busy), 64'h0);

    // Ordering.
    add(16'h5BA3, 2'd0, 1'b0);
    add(16'h5AB7, 2'd1, 1'b0);
    add(16'h5DC1, 2'd2, 1'b0);
    check("order_count", 64'(queue_count), 64'd3);
    s = cyc;
    clrq.push_back(s + 1);
    exp_tx(s + 2, 0, 16'h5BA3);
    exp_tx(s + 7, 1, 16'h5AB7);
    exp_tx(s + 12, 2, 16'h5DC1);
    doneq.push_back(s + 17);
    send();
    check("order_busy_rise", 64'(busy), 64'h1);
    wait_until(s + 17);
    check("order_busy_at_done", 64'(busy), 64'h1);
    wait_until(s + 18);
    check("order_busy_fall", 64'(busy), 64'h0);
    check("order_count_end", 64'(queue_count), 64'd0);

    // Full / drop.
    add(16'h5111, 2'd0, 1'b0);
    add(16'h5222, 2'd1, 1'b0);
    add(16'h5333, 2'd2, 1'b0);
    add(16'h5444, 2'd3, 1'b0);
    check("fill_count", 64'(queue_count), 64'd4);
    check("fill_full", 64'(full), 64'h1);
    add(16'h5555, 2'd0, 1'b1);
    check("drop_count", 64'(queue_count), 64'd4);
    check("drop_full", 64'(full), 64'h1);
    s = cyc;
    clrq.push_back(s + 1);
    exp_tx(s + 2, 0, 16'h5111);
    exp_tx(s + 7, 1, 16'h5222);
    exp_tx(s + 12, 2, 16'h5333);
    exp_tx(s + 17, 3, 16'h5444);
    doneq.push_back(s + 22);
    send();
    wait_until(s + 23);
    check("drain_count", 64'(queue_count), 64'd0);
    check("drain_full", 64'(full), 64'h0);

    // Mid-burst add joins the running burst.
    add(16'h5A11, 2'd0, 1'b0);
    add(16'h5A22, 2'd1, 1'b0);
    s = cyc;
    clrq.push_back(s + 1);
    exp_tx(s + 2, 0, 16'h5A11);
    exp_tx(s + 7, 1, 16'h5A22);
    exp_tx(s + 12, 3, 16'h5ABF);
    doneq.push_back(s + 17);
    send();
    wait_until(s + 4);
    add(16'h5ABF, 2'd3, 1'b0);
    wait_until(s + 18);
    check("mid_count_end", 64'(queue_count), 64'd0);
    check("mid_busy_end", 64'(busy), 64'h0);

    // Full queue: add coincides with the first pop.
    add(16'h6011, 2'd0, 1'b0);
    add(16'h6022, 2'd1, 1'b0);
    add(16'h6033, 2'd2, 1'b0);
    add(16'h6044, 2'd3, 1'b0);
    s = cyc;
    clrq.push_back(s + 1);
    exp_tx(s + 2, 0, 16'h6011);
    exp_tx(s + 7, 1, 16'h6022);
    exp_tx(s + 12, 2, 16'h6033);
    exp_tx(s + 17, 3, 16'h6044);
    exp_tx(s + 22, 1, 16'h6055);
    doneq.push_back(s + 27);
    send();
    wait_until(s + 2);
    add(16'h6055, 2'd1, 1'b0);
    check("pop_add_count", 64'(queue_count), 64'd4);
    check("pop_add_full", 64'(full), 64'h1);
    wait_until(s + 28);
    check("pop_add_count_end", 64'(queue_count), 64'd0);

    // Reset in the gap after the second dispatch.
    add(16'h7011, 2'd0, 1'b0);
    add(16'h7022, 2'd1, 1'b0);
    add(16'h7033, 2'd2, 1'b0);
    s = cyc;
    clrq.push_back(s + 1);
    exp_tx(s + 2, 0, 16'h7011);
    exp_tx(s + 7, 1, 16'h7022);
    send();
    wait_until(s + 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_count", 64'(queue_count), 64'd0);
    check("rst_mid_frame", tx_frame_flat, 64'h0);
    repeat (20) @(negedge clk);
    s = cyc;
    doneq.push_back(s + 1);
    send();
    repeat (5) @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'h0);

    check("left_tx", 64'(txq.size()), 64'd0);
    check("left_clear", 64'(clrq.size()), 64'd0);
    check("left_done", 64'(doneq.size()), 64'd0);
    check("left_drop", 64'(dropq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
# frame_tx_scheduler

Paced transmit scheduler between the user-entry logic and the four EndDevice transmitters of the L2 switch simulator. It holds up to four pending frames in a FIFO. On a send request it clears the switch FIFOs once, then dispatches the queued frames one at a time in arrival order, each to its source node's port. A programmable gap separates consecutive dispatches so that serial frames never overlap inside the switch.

## Interface
- GAP_CYCLES, 40, idle cycles after each dispatch before the next one (legal values ≥1)
- DEPTH, 4, queue depth (fixed at 4; pointers are 2 bits)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- add_req  in  1  one-cycle pulse: enqueue add_frame/add_src
- add_frame  in  16  frame {SFD[15:12], DST[11:8], SRC[7:4], PAYLOAD[3:0]}
- add_src  in  2  transmitting node index (0=A, 1=B, 2=C, 3=D)
- send_req  in  1  one-cycle pulse: start a dispatch burst
- tx_frame_flat  out  64  per-port frame; port p occupies [16p+15:16p]; holds its last value between dispatches
- tx_valid  out  4  one-cycle dispatch strobe; one bit per port
- clear_fifos  out  1  one-cycle pulse to the switch at burst start
- queue_count  out  3  number of frames in the queue (0..4)
- full  out  1  queue_count==4
- busy  out  1  high whenever state≠IDLE
- drop  out  1  one-cycle pulse: add_req was rejected because the queue was full
- done  out  1  one-cycle pulse: burst finished

## Operation
- Queue: circular FIFO with 2-bit head/tail pointers that wrap 3→0, plus a 3-bit count. Each entry stores the 16-bit frame and the 2-bit src.
- Enqueue: add_req && !full writes the entry at tail. tail and count are incremented.
- Full queue: add_req && full drops the frame, pulses drop, and leaves queue state unchanged.
- Enqueue is accepted in every state.
- States:
  - IDLE: on send_req && count>0, go to CLEAR. On send_req && count==0, pulse done and stay in IDLE; clear_fifos is not pulsed.
  - CLEAR: clear_fifos=1 for this cycle, then go to DISPATCH.
  - DISPATCH: pop the head entry, load tx_frame_flat[src] with its frame, set tx_valid[src]=1, and load the gap counter with GAP_CYCLES. Go to GAP.
  - GAP: decrement the counter. When the counter reaches 1 and the cycle completes, go to DISPATCH if count>0; otherwise go to DONE.
  - DONE: pulse done, then go to IDLE.
- Frames enqueued during a burst (before GAP exits) join the same burst.
- send_req outside IDLE is ignored.
- Simultaneous add_req and pop in DISPATCH: both take effect and count is unchanged. When full, the pop frees the slot in the same cycle, so the add is accepted with no drop.
- add_req and send_req in the same IDLE cycle: the add is accepted. The burst starts only if the count before the add was >0; otherwise done pulses and the new frame stays queued.
- Per-port tx_frame_flat registers change only on a dispatch to that port.
- Width of the gap counter is $clog2(GAP_CYCLES+1) bits.
- Reset (including mid-burst): state=IDLE, head=tail=count=0, and the gap counter is cleared. Queue contents are discarded; no partial frame is emitted.

## Timing
- All outputs are registered.
- Reset values: tx_frame_flat=0, tx_valid=0, clear_fifos=0, queue_count=0, full=0, busy=0, drop=0, done=0.
- Enqueue latency: queue_count and full update 1 cycle after add_req.
- Drop latency: drop pulses 1 cycle after the rejected add_req.
- With send_req sampled at edge 0:
  - clear_fifos is high in cycle 1.
  - The first tx_valid is high in cycle 2.
  - Consecutive tx_valid pulses are GAP_CYCLES+1 cycles apart.
  - done is high GAP_CYCLES+1 cycles after the last tx_valid.
- busy rises in cycle 1 and falls in the cycle after done.
- tx_frame_flat for the dispatched port is valid in the same cycle as its tx_valid bit.
- At most one tx_valid bit is high in any cycle.

## Test plan
- Reset then idle: with no stimulus, all outputs stay 0 for 100 cycles. send_req on the empty queue → done pulses 1 cycle later; clear_fifos stays 0.
- Ordering (GAP_CYCLES=4): enqueue 0x5BA3 (src 0), 0x5AB7 (src 1), 0x5DC1 (src 2); send_req at cycle 0 →
  - clear_fifos at cycle 1
  - tx_valid=0001 with port0=0x5BA3 at cycle 2
  - tx_valid=0010 with port1=0x5AB7 at cycle 7
  - tx_valid=0100 with port2=0x5DC1 at cycle 12
  - done at cycle 17
- Full/drop: 5 add_req pulses → queue_count=4, full=1, and exactly one drop pulse on the 5th add. A burst then emits 4 strobes and ends with queue_count=0.
- Mid-burst add: during the GAP after the first dispatch, add 0x5ABF (src 3) → it is emitted in the same burst as tx_valid=1000, after the previously queued frames.
- Full plus pop: with the queue full, add_req coincides with a DISPATCH pop → no drop pulse and queue_count stays 4.
- Reset mid-burst: assert rst in the GAP after the 2nd dispatch → busy=0 and queue_count=0 in the next cycle, with no further tx_valid. A subsequent send_req gives only a done pulse.
